cpu_run_ctrl: RTL

Run controller for the Hack CPU on the FPGA board. It sits between the clock/reset generator and the CPU/Memory pair. It stretches reset into the CPU, then drives a single clock-enable (`cpu_en`) that gates CPU state updates and Memory writes. It supports run, halt, single-step and a PC breakpoint, and counts enabled cycles for debug readout.

---
 rtl/cpu_run_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the Hack CPU.
// Stretches reset into the CPU, then gates CPU/Memory updates through cpu_en
// with run / halt / single-step control and a cycle counter for debug readout.
// Breakpoint logic (bp_stop, skip flag, bp_hit) is built only when the macro
// CPU_RUN_CTRL_BREAKPOINT_EN is defined; otherwise bp_hit is tied low.
module cpu_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 20,
    parameter int unsigned AUTO_RUN     = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic             step,
    input  logic             restart,
    input  logic [15:0]      pc,
    input  logic [15:0]      bp_addr,
    input  logic             bp_valid,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic             halted,
    output logic             bp_hit,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_HALT = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    localparam logic [7:0] RST_LOAD = 8'(RESET_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] rst_cnt;
    logic       bp_stop;
    logic       clr;

    assign state     = state_q;
    assign cpu_reset = (state_q == ST_RST);
    assign halted    = (state_q == ST_HALT);

    // Counter and sticky flag are cleared while in RST and on the edge that enters it.
    assign clr = (state_q == ST_RST) || (state_d == ST_RST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and clock-enable generation
    always_comb begin
        state_d = state_q;
        cpu_en  = 1'b0;
        unique case (state_q)
            ST_RST: begin
                if (restart) begin
                    state_d = ST_RST;
                end else if (rst_cnt == 8'd0) begin
                    state_d = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;
                end
            end
            ST_HALT: begin
                if (restart) begin
                    state_d = ST_RST;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (step) begin
                    state_d = ST_STEP;
                end else if (run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cpu_en = !halt_req && !bp_stop;
                if (restart) begin
                    state_d = ST_RST;
                end else if (halt_req || bp_stop) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                cpu_en  = 1'b1;
                state_d = restart ? ST_RST : ST_HALT;
            end
        endcase
    end

    // Reset-stretch down-counter: reloads on any entry to RST or restart while in RST
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cnt <= RST_LOAD;
        end else if ((state_d == ST_RST) && ((state_q != ST_RST) || restart)) begin
            rst_cnt <= RST_LOAD;
        end else if ((state_q == ST_RST) && (rst_cnt != 8'd0)) begin
            rst_cnt <= rst_cnt - 8'd1;
        end
    end

    // Enabled-cycle counter, wraps silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (clr) begin
            cycle_count <= '0;
        end else if (cpu_en) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic skip_q;

    // skip_q lets the instruction sitting at bp_addr execute once after a resume.
    assign bp_stop = bp_valid && (pc == bp_addr) && !skip_q;

    // Skip flag: armed on HALT->RUN, dropped after the first RUN cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_q <= 1'b0;
        end else if ((state_q == ST_HALT) && (state_d == ST_RUN)) begin
            skip_q <= 1'b1;
        end else if (state_q == ST_RUN) begin
            skip_q <= 1'b0;
        end
    end

    // Sticky breakpoint-hit flag; any accepted command out of HALT clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_hit <= 1'b0;
        end else if (clr) begin
            bp_hit <= 1'b0;
        end else if ((state_q == ST_HALT) && (state_d != ST_HALT)) begin
            bp_hit <= 1'b0;
        end else if ((state_q == ST_RUN) && bp_stop) begin
            bp_hit <= 1'b1;
        end
    end
`else
    logic unused_bp;

    assign bp_stop   = 1'b0;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
`endif

endmodule
